// File: rtl/cpu_debug_ctrl_pkg.sv
// Opcode and FSM state encodings shared by the run-control unit and its bench.
package cpu_debug_ctrl_pkg;

  typedef enum logic [2:0] {
    OP_NOP       = 3'd0,
    OP_HALT      = 3'd1,
    OP_STEP      = 3'd2,
    OP_RUN_N     = 3'd3,
    OP_RUN_FREE  = 3'd4,
    OP_SET_BP    = 3'd5,
    OP_CLR_TRACE = 3'd6,
    OP_RUN_BP    = 3'd7
  } dbg_op_e;

  typedef enum logic [2:0] {
    ST_HALT     = 3'd0,
    ST_STEP     = 3'd1,
    ST_RUN_N    = 3'd2,
    ST_RUN_FREE = 3'd3,
    ST_RUN_BP   = 3'd4
  } dbg_state_e;

  function automatic logic is_run_op(input dbg_op_e op);
    return (op == OP_STEP) || (op == OP_RUN_N) || (op == OP_RUN_FREE) || (op == OP_RUN_BP);
  endfunction

endpackage

// File: rtl/cpu_debug_ctrl_trace_buf.sv
// Circular trace store: write pointer, saturating entry count, sticky wrap flag,
// and a combinational read indexed from the oldest valid entry.
module cpu_debug_ctrl_trace_buf
  import cpu_debug_ctrl_pkg::*;
#(
  parameter int W     = 160,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_clr,
  input  logic          i_wr_en,
  input  logic [W-1:0]  i_wr_data,
  input  logic [AW-1:0] i_rd_idx,
  output logic [W-1:0]  o_rd_data,
  output logic [AW:0]   o_count,
  output logic          o_wrapped
);

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW:0]   r_count;
  logic          r_wrapped;
  logic [AW-1:0] w_rd_addr;
  logic          w_rd_valid;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr  <= '0;
      r_count   <= '0;
      r_wrapped <= 1'b0;
    end else if (i_clr) begin
      r_wr_ptr  <= '0;
      r_count   <= '0;
      r_wrapped <= 1'b0;
    end else if (i_wr_en) begin
      r_wr_ptr <= r_wr_ptr + 1'b1;
      if (r_count == FULL) r_wrapped <= 1'b1;
      else                 r_count   <= r_count + 1'b1;
    end
  end

  // Contents need no reset: reads beyond the valid count are forced to zero.
  always_ff @(posedge i_clk) begin
    if (i_wr_en && !i_clr) r_mem[r_wr_ptr] <= i_wr_data;
  end

  // When full, the low count bits are zero and the oldest entry sits at the write pointer.
  assign w_rd_addr  = r_wr_ptr - r_count[AW-1:0] + i_rd_idx;
  assign w_rd_valid = ({1'b0, i_rd_idx} < r_count);
  assign o_rd_data  = w_rd_valid ? r_mem[w_rd_addr] : '0;
  assign o_count    = r_count;
  assign o_wrapped  = r_wrapped;

endmodule

// File: rtl/cpu_debug_ctrl.sv
// Run-control (clock-enable) FSM for the debug CPU with breakpoint compare and trace capture.
//   state       | meaning
//   ST_HALT     | CPU frozen, commands accepted
//   ST_STEP     | one enabled cycle, then halt
//   ST_RUN_N    | enabled while step counter counts down to zero
//   ST_RUN_FREE | enabled until a HALT command
//   ST_RUN_BP   | enabled until pc_in matches the breakpoint
module cpu_debug_ctrl
  import cpu_debug_ctrl_pkg::*;
#(
  parameter int PW     = 32,
  parameter int NPROBE = 4,
  parameter int DEPTH  = 16,
  parameter int CNTW   = 16
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_cmd_valid,
  output logic                       o_cmd_ready,
  input  logic [2:0]                 i_cmd_op,
  input  logic [PW-1:0]              i_cmd_arg,
  output logic                       o_cpu_ce,
  input  logic [PW-1:0]              i_pc_in,
  input  logic [NPROBE*PW-1:0]       i_probe_in,
  output logic                       o_halted,
  output logic                       o_bp_hit,
  input  logic [$clog2(DEPTH)-1:0]   i_trace_rd_idx,
  output logic [(NPROBE+1)*PW-1:0]   o_trace_rd_data,
  output logic [$clog2(DEPTH):0]     o_trace_count,
  output logic                       o_trace_wrapped
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = (NPROBE + 1) * PW;

  dbg_state_e    r_state, w_state_nxt;
  logic [CNTW-1:0] r_cnt, w_cnt_nxt;
  logic [PW-1:0] r_bp_addr;
  logic          r_bp_hit, w_bp_hit_nxt;
  logic          w_ce;
  logic          w_bp_match;
  logic          w_clr;
  dbg_op_e       w_op;

  assign w_op       = dbg_op_e'(i_cmd_op);
  assign w_bp_match = (i_pc_in == r_bp_addr);
  assign w_clr      = i_cmd_valid && (w_op == OP_CLR_TRACE);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= ST_HALT;
      r_cnt    <= '0;
      r_bp_hit <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_bp_hit <= w_bp_hit_nxt;
    end
  end

  // The breakpoint compare always sees the value held before any SET_BP in the same cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                                   r_bp_addr <= '0;
    else if (i_cmd_valid && (w_op == OP_SET_BP))    r_bp_addr <= i_cmd_arg;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_bp_hit_nxt = r_bp_hit;
    w_ce         = 1'b0;
    case (r_state)
      ST_HALT: begin
        if (i_cmd_valid) begin
          if (is_run_op(w_op)) w_bp_hit_nxt = 1'b0;
          case (w_op)
            OP_STEP:     w_state_nxt = ST_STEP;
            OP_RUN_FREE: w_state_nxt = ST_RUN_FREE;
            OP_RUN_BP:   w_state_nxt = ST_RUN_BP;
            OP_RUN_N: begin
              if (i_cmd_arg[CNTW-1:0] != '0) begin
                w_state_nxt = ST_RUN_N;
                w_cnt_nxt   = i_cmd_arg[CNTW-1:0];
              end
            end
            default: ;
          endcase
        end
      end
      ST_STEP: begin
        w_ce        = 1'b1;
        w_state_nxt = ST_HALT;
      end
      ST_RUN_N: begin
        w_ce      = 1'b1;
        w_cnt_nxt = r_cnt - 1'b1;
        if (r_cnt == CNTW'(1)) w_state_nxt = ST_HALT;
      end
      ST_RUN_FREE: w_ce = 1'b1;
      ST_RUN_BP: begin
        // A matching pc is never executed: enable is withheld in the match cycle.
        if (w_bp_match) begin
          w_state_nxt  = ST_HALT;
          w_bp_hit_nxt = 1'b1;
        end else begin
          w_ce = 1'b1;
        end
      end
      default: w_state_nxt = ST_HALT;
    endcase
    if ((r_state != ST_HALT) && i_cmd_valid && (w_op == OP_HALT)) w_state_nxt = ST_HALT;
  end

  cpu_debug_ctrl_trace_buf #(
    .W     (EW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_trace_buf (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_clr     (w_clr),
    .i_wr_en   (w_ce),
    .i_wr_data ({i_pc_in, i_probe_in}),
    .i_rd_idx  (i_trace_rd_idx),
    .o_rd_data (o_trace_rd_data),
    .o_count   (o_trace_count),
    .o_wrapped (o_trace_wrapped)
  );

  assign o_cmd_ready = 1'b1;
  assign o_cpu_ce    = w_ce;
  assign o_halted    = (r_state == ST_HALT);
  assign o_bp_hit    = r_bp_hit;

endmodule

// File: tb/tb_cpu_debug_ctrl.sv
// Bench for cpu_debug_ctrl: behavioural run/trace model checked every cycle,
// directed scenarios with literal expectations, then randomized commands.
module tb_cpu_debug_ctrl;
  import cpu_debug_ctrl_pkg::*;

  localparam int PW = 32, NPROBE = 4, DEPTH = 16, CNTW = 16, AW = 4;
  localparam int EW = (NPROBE + 1) * PW;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              i_cmd_valid, o_cmd_ready, o_cpu_ce, o_halted, o_bp_hit, o_trace_wrapped;
  logic [2:0]        i_cmd_op;
  logic [PW-1:0]     i_cmd_arg, i_pc_in;
  logic [NPROBE*PW-1:0] i_probe_in;
  logic [AW-1:0]     i_trace_rd_idx;
  logic [EW-1:0]     o_trace_rd_data;
  logic [AW:0]       o_trace_count;

  always #5 clk = ~clk;

  cpu_debug_ctrl #(.PW(PW), .NPROBE(NPROBE), .DEPTH(DEPTH), .CNTW(CNTW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
    .i_cmd_op(i_cmd_op), .i_cmd_arg(i_cmd_arg), .o_cpu_ce(o_cpu_ce), .i_pc_in(i_pc_in),
    .i_probe_in(i_probe_in), .o_halted(o_halted), .o_bp_hit(o_bp_hit),
    .i_trace_rd_idx(i_trace_rd_idx), .o_trace_rd_data(o_trace_rd_data),
    .o_trace_count(o_trace_count), .o_trace_wrapped(o_trace_wrapped)
  );

  int total = 0;
  int bad = 0;
  int ce_seen = 0;

  // Model: remaining enabled cycles (0 = halted, -1 = unbounded) plus a trace queue.
  int            m_left = 0;
  bit            m_bpm = 1'b0;
  logic [PW-1:0] m_bp = '0;
  bit            m_hit = 1'b0;
  bit            m_wrap = 1'b0;
  bit            m_ce_last = 1'b0;
  logic [EW-1:0] m_tr[$];

  task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic bit model_ce();
    return (m_left != 0) && !(m_bpm && (i_pc_in == m_bp));
  endfunction

  always @(posedge clk or negedge rst_n) begin
    bit ce, was_halted;
    if (!rst_n) begin
      m_left = 0; m_bpm = 0; m_bp = '0; m_hit = 0; m_wrap = 0; m_ce_last = 0;
      m_tr.delete();
    end else begin
      ce = model_ce();
      was_halted = (m_left == 0);
      if (ce) begin
        m_tr.push_back({i_pc_in, i_probe_in});
        if (m_tr.size() > DEPTH) begin
          void'(m_tr.pop_front());
          m_wrap = 1;
        end
        if (m_left > 0) m_left--;
      end else if (m_left != 0) begin
        m_left = 0;
        m_hit = 1;
      end
      if (i_cmd_valid) begin
        case (i_cmd_op)
          OP_HALT:      m_left = 0;
          OP_STEP:      if (was_halted) begin m_hit = 0; m_left = 1; end
          OP_RUN_N:     if (was_halted) begin m_hit = 0; m_left = int'(i_cmd_arg[CNTW-1:0]); end
          OP_RUN_FREE:  if (was_halted) begin m_hit = 0; m_left = -1; end
          OP_RUN_BP:    if (was_halted) begin m_hit = 0; m_left = -1; m_bpm = 1; end
          OP_SET_BP:    m_bp = i_cmd_arg;
          OP_CLR_TRACE: begin m_tr.delete(); m_wrap = 0; end
          default: ;
        endcase
      end
      if (m_left == 0) m_bpm = 0;
      m_ce_last = ce;
    end
  end

  always @(negedge clk) begin
    logic [EW-1:0] exp_rd;
    int idx;
    idx = int'(i_trace_rd_idx);
    exp_rd = (idx < m_tr.size()) ? m_tr[idx] : '0;
    check("cpu_ce", o_cpu_ce, model_ce());
    check("halted", o_halted, m_left == 0);
    check("bp_hit", o_bp_hit, m_hit);
    check("cmd_ready", o_cmd_ready, 1'b1);
    check("trace_count", o_trace_count, m_tr.size());
    check("trace_wrapped", o_trace_wrapped, m_wrap);
    check("trace_rd_data", o_trace_rd_data, exp_rd);
    if (o_cpu_ce) ce_seen++;
  end

  task automatic tick(input bit v, input logic [2:0] op, input logic [PW-1:0] arg);
    @(posedge clk);
    #1;
    if (m_ce_last) i_pc_in = i_pc_in + 32'd4;
    i_cmd_valid = v;
    i_cmd_op    = op;
    i_cmd_arg   = arg;
    for (int c = 0; c < NPROBE; c++) i_probe_in[c*PW +: PW] = $urandom;
    i_trace_rd_idx = AW'($urandom_range(0, DEPTH - 1));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, OP_NOP, '0);
  endtask

  task automatic peek_pc(input int idx, output logic [PW-1:0] pc);
    i_trace_rd_idx = AW'(idx);
    #1;
    pc = o_trace_rd_data[EW-1 -: PW];
  endtask

  initial begin
    logic [PW-1:0] pc;
    int c0;
    i_cmd_valid = 0; i_cmd_op = OP_NOP; i_cmd_arg = '0; i_pc_in = '0;
    i_probe_in = '0; i_trace_rd_idx = '0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_halted", o_halted, 1);
    check("rst_ce", o_cpu_ce, 0);
    check("rst_count", o_trace_count, 0);
    check("rst_bp_hit", o_bp_hit, 0);
    check("rst_wrapped", o_trace_wrapped, 0);
    rst_n = 1'b1;
    idle(2);

    // Three single steps from pc 0.
    c0 = ce_seen;
    for (int i = 0; i < 3; i++) begin
      tick(1, OP_STEP, '0);
      idle(2);
    end
    check("t1_ce_cycles", ce_seen - c0, 3);
    check("t1_count", o_trace_count, 3);
    check("t1_halted", o_halted, 1);
    peek_pc(0, pc); check("t1_idx0_pc", pc, 32'h0);
    peek_pc(2, pc); check("t1_idx2_pc", pc, 32'h8);

    // RUN_N 5, then RUN_N 0.
    tick(1, OP_CLR_TRACE, '0);
    c0 = ce_seen;
    tick(1, OP_RUN_N, 32'd5);
    idle(8);
    check("t2_ce_cycles", ce_seen - c0, 5);
    check("t2_halted", o_halted, 1);
    check("t2_count", o_trace_count, 5);
    c0 = ce_seen;
    tick(1, OP_RUN_N, 32'd0);
    idle(3);
    check("t2_run0_ce", ce_seen - c0, 0);
    check("t2_run0_halted", o_halted, 1);

    // Breakpoint at 0x20.
    tick(1, OP_CLR_TRACE, '0);
    i_pc_in = '0;
    tick(1, OP_SET_BP, 32'h20);
    c0 = ce_seen;
    tick(1, OP_RUN_BP, '0);
    idle(12);
    check("t3_ce_cycles", ce_seen - c0, 8);
    check("t3_bp_hit", o_bp_hit, 1);
    check("t3_halted", o_halted, 1);
    check("t3_count", o_trace_count, 8);
    peek_pc(7, pc); check("t3_last_pc", pc, 32'h1C);

    // Wrap: 20 cycles into a 16-deep buffer.
    tick(1, OP_CLR_TRACE, '0);
    i_pc_in = '0;
    tick(1, OP_RUN_N, 32'd20);
    idle(24);
    check("t4_count", o_trace_count, 16);
    check("t4_wrapped", o_trace_wrapped, 1);
    check("t4_bp_hit_cleared", o_bp_hit, 0);
    peek_pc(0, pc);  check("t4_idx0_pc", pc, 32'h10);
    peek_pc(15, pc); check("t4_idx15_pc", pc, 32'h4C);

    // Free run halted by command after 7 enabled cycles.
    tick(1, OP_RUN_FREE, '0);
    c0 = ce_seen;
    idle(6);
    tick(1, OP_HALT, '0);
    idle(1);
    check("t5_ce_cycles", ce_seen - c0, 7);
    check("t5_ce_low", o_cpu_ce, 0);
    check("t5_halted", o_halted, 1);

    // Clear during capture.
    tick(1, OP_RUN_FREE, '0);
    idle(3);
    tick(1, OP_CLR_TRACE, '0);
    idle(1);
    check("t5_clr_count", o_trace_count, 0);
    check("t5_clr_wrapped", o_trace_wrapped, 0);
    i_trace_rd_idx = '0;
    #1 check("t5_clr_idx0", o_trace_rd_data, '0);
    tick(1, OP_HALT, '0);
    idle(2);

    // Reset mid free-run.
    tick(1, OP_RUN_FREE, '0);
    idle(4);
    rst_n = 1'b0;
    #1;
    check("t6_rst_ce", o_cpu_ce, 0);
    check("t6_rst_halted", o_halted, 1);
    check("t6_rst_count", o_trace_count, 0);
    idle(2);
    rst_n = 1'b1;
    idle(4);
    check("t6_post_halted", o_halted, 1);
    check("t6_post_ce", o_cpu_ce, 0);

    // Randomized command traffic.
    for (int i = 0; i < 600; i++) begin
      logic [2:0] op;
      logic [PW-1:0] arg;
      op = 3'($urandom_range(0, 7));
      case (op)
        OP_RUN_N:             arg = PW'($urandom_range(0, 20));
        OP_SET_BP, OP_RUN_BP: arg = i_pc_in + PW'(4 * $urandom_range(0, 12));
        default:              arg = $urandom;
      endcase
      tick($urandom_range(0, 15) < 3, op, arg);
    end
    tick(1, OP_HALT, '0);
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
